plot_writer: RTL

- Downstream consumer of the coordinate zoom stage.
- Takes signed 8-bit zoomed X/Y points with a VALID strobe and buffers them in a small FIFO, because the zoom stage has no backpressure.
- Maps each point to a 256x256 framebuffer address and issues pixel writes to the video-memory arbiter over a REQ/ACK handshake.

---
 rtl/plot_pkg.sv | 30 +++
 rtl/plot_fifo.sv | 52 +++++
 rtl/plot_writer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/plot_pkg.sv
// Shared types and helpers for the plot writer: framebuffer geometry, FSM
// states and the coordinate-to-address mapping.
package plot_pkg;

  localparam int SCR_BITS = 8;
  localparam int ADDR_W   = 16;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    CLEAR
  } plot_state_t;

  // Screen position of a buffered point; colour travels alongside it.
  typedef struct packed {
    logic [SCR_BITS-1:0] col;
    logic [SCR_BITS-1:0] row;
  } plot_point_t;

  // Y grows upward on screen, so row 0 sits at Y=127; X is offset-binary.
  function automatic logic [ADDR_W-1:0] coord_to_addr(input logic signed [7:0] x,
                                                      input logic signed [7:0] y);
    logic [SCR_BITS-1:0] row;
    logic [SCR_BITS-1:0] col;
    row = 8'd127 - y;
    col = x ^ 8'h80;
    return {row, col};
  endfunction

endpackage

// File: rtl/plot_fifo.sv
// Synchronous point FIFO; full/empty derive from an occupancy counter.
module plot_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/plot_writer.sv
// Buffers zoomed points and writes them to the framebuffer over REQ/ACK.
// Optional full-frame clear is built when PLOT_CLEAR_EN is defined.
module plot_writer
  import plot_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int COLOR_W    = 8
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic signed [7:0]   Xin,
  input  logic signed [7:0]   Yin,
  input  logic                VALID_IN,
  input  logic [COLOR_W-1:0]  COLOR,
  output logic                MEM_REQ,
  output logic [ADDR_W-1:0]   MEM_ADDR,
  output logic [COLOR_W-1:0]  MEM_DATA,
  input  logic                MEM_ACK,
  output logic                FIFO_FULL,
  output logic [7:0]          OVF_CNT
`ifdef PLOT_CLEAR_EN
  ,
  input  logic                CLEAR_REQ,
  input  logic [COLOR_W-1:0]  BG_COLOR,
  output logic                CLEAR_BUSY
`endif
);

  localparam int ENTRY_W = $bits(plot_point_t) + COLOR_W;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  plot_state_t        state;
  plot_state_t        state_nxt;
  logic               pop;
  logic               done;
  logic               fifo_empty;
  logic               fifo_full;
  logic [ADDR_W-1:0]  addr_in;
  plot_point_t        pt_in;
  plot_point_t        pt_out;
  logic [COLOR_W-1:0] color_out;
  logic [ENTRY_W-1:0] fifo_din;
  logic [ENTRY_W-1:0] fifo_dout;

  assign addr_in  = coord_to_addr(Xin, Yin);
  assign pt_in    = '{col: addr_in[SCR_BITS-1:0], row: addr_in[ADDR_W-1:SCR_BITS]};
  assign fifo_din = {pt_in, COLOR};
  assign {pt_out, color_out} = fifo_dout;

  plot_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .push    (VALID_IN),
    .pop     (pop),
    .din     (fifo_din),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign FIFO_FULL = fifo_full;
  assign MEM_REQ   = (state != IDLE);
  assign done      = MEM_REQ && MEM_ACK;

`ifdef PLOT_CLEAR_EN
  logic clr_pend;
  logic load_clr;

  assign CLEAR_BUSY = (state == CLEAR);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      clr_pend <= 1'b0;
    end else if (load_clr) begin
      clr_pend <= 1'b0;
    end else if (CLEAR_REQ && state != CLEAR) begin
      clr_pend <= 1'b1;
    end
  end
`endif

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= IDLE;
    else          state <= state_nxt;
  end

  // The output register is free when idle or on the edge its transfer completes.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
`ifdef PLOT_CLEAR_EN
    load_clr  = 1'b0;
`endif
    case (state)
      IDLE, WRITE: begin
        if (state == IDLE || done) begin
`ifdef PLOT_CLEAR_EN
          if (clr_pend) begin
            state_nxt = CLEAR;
            load_clr  = 1'b1;
          end else
`endif
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = WRITE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
`ifdef PLOT_CLEAR_EN
      CLEAR: begin
        if (done && MEM_ADDR == '1) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = WRITE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      MEM_ADDR <= '0;
      MEM_DATA <= '0;
    end else if (pop) begin
      MEM_ADDR <= {pt_out.row, pt_out.col};
      MEM_DATA <= color_out;
    end
`ifdef PLOT_CLEAR_EN
    else if (load_clr) begin
      MEM_ADDR <= '0;
      MEM_DATA <= BG_COLOR;
    end else if (state == CLEAR && done) begin
      MEM_ADDR <= MEM_ADDR + 1'b1;
    end
`endif
  end

  // Full is sampled before the edge, so a same-edge pop never rescues a point.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)                    OVF_CNT <= 8'd0;
    else if (VALID_IN && fifo_full)  OVF_CNT <= sat_inc8(OVF_CNT);
  end

endmodule
